instruction_fetch: RTL and testbench

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

---
 rtl/instruction_fetch.sv | 125 ++++++++++++
 tb/tb_instruction_fetch.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: owns the PC, the IF/ID pipeline register and the
// BOOT/RUN/HALT sequencing, including redirect, stall and EBREAK halt handling.
module instruction_fetch #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR  = 32'h0000_0013,
  parameter logic [31:0] HALT_INSTR = 32'h0010_0073
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_target,
  output logic [31:0] PC,
  input  logic [31:0] instruction,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_instr,
  output logic        if_id_valid,
  output logic        misaligned,
  output logic        halted,
  output logic [31:0] fetch_count
);

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_id_pc;
  logic [31:0] r_id_instr;
  logic        r_id_valid;
  logic        r_misaligned;
  logic        r_halted;
  logic [31:0] r_count;

  state_t      w_state_next;
  logic [31:0] w_pc_next;
  logic [31:0] w_id_pc_next;
  logic [31:0] w_id_instr_next;
  logic        w_id_valid_next;
  logic        w_misaligned_next;
  logic        w_halted_next;
  logic [31:0] w_count_next;
  logic        w_is_halt;

  assign w_is_halt = (instruction == HALT_INSTR);

  // Branch order inside RUN encodes the priority redirect > stall > halt > advance.
  always_comb begin
    // NOTE: every output of this block gets a hold value first so no path
    // through the case can leave one unassigned and infer a latch.
    w_state_next      = r_state;
    w_pc_next         = r_pc;
    w_id_pc_next      = r_id_pc;
    w_id_instr_next   = r_id_instr;
    w_id_valid_next   = r_id_valid;
    w_misaligned_next = r_misaligned;
    w_halted_next     = r_halted;
    w_count_next      = r_count;

    case (r_state)
      ST_BOOT: w_state_next = ST_RUN;
      ST_RUN: begin
        if (redirect) begin
          w_pc_next         = {redirect_target[31:2], 2'b00};
          w_id_instr_next   = NOP_INSTR;
          w_id_valid_next   = 1'b0;
          w_misaligned_next = r_misaligned | (|redirect_target[1:0]);
        end else if (!stall) begin
          w_id_pc_next    = r_pc;
          w_id_instr_next = instruction;
          w_id_valid_next = 1'b1;
          w_count_next    = r_count + 32'd1;
          if (w_is_halt) begin
            w_state_next  = ST_HALT;
            w_halted_next = 1'b1;
          end else begin
            w_pc_next = r_pc + 32'd4;
          end
        end
      end
      ST_HALT: begin
        w_id_instr_next = NOP_INSTR;
        w_id_valid_next = 1'b0;
        w_halted_next   = 1'b1;
      end
      default: w_state_next = ST_BOOT;
    endcase
  end

  // NOTE: all state is updated with non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_BOOT;
      r_pc         <= RESET_PC;
      r_id_pc      <= 32'd0;
      r_id_instr   <= NOP_INSTR;
      r_id_valid   <= 1'b0;
      r_misaligned <= 1'b0;
      r_halted     <= 1'b0;
      r_count      <= 32'd0;
    end else begin
      r_state      <= w_state_next;
      r_pc         <= w_pc_next;
      r_id_pc      <= w_id_pc_next;
      r_id_instr   <= w_id_instr_next;
      r_id_valid   <= w_id_valid_next;
      r_misaligned <= w_misaligned_next;
      r_halted     <= w_halted_next;
      r_count      <= w_count_next;
    end
  end

  assign PC          = r_pc;
  assign if_id_pc    = r_id_pc;
  assign if_id_instr = r_id_instr;
  assign if_id_valid = r_id_valid;
  assign misaligned  = r_misaligned;
  assign halted      = r_halted;
  assign fetch_count = r_count;

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: per-scenario stimulus tables,
// expected snapshots queued as each cycle is driven and compared after the edge.
module tb_instruction_fetch;

  localparam logic [31:0] NOP  = 32'h0000_0013;
  localparam logic [31:0] HALT = 32'h0010_0073;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_target;
  logic [31:0] PC;
  logic [31:0] instruction;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_instr;
  logic        if_id_valid;
  logic        misaligned;
  logic        halted;
  logic [31:0] fetch_count;

  logic [31:0] mem [64];

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic        rst;
    logic        st;
    logic        rd;
    logic [31:0] tgt;
  } stim_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] id_pc;
    logic [31:0] id_instr;
    logic [31:0] cnt;
    logic        v;
    logic        h;
    logic        m;
  } obs_t;

  obs_t sb[$];

  instruction_fetch dut (
    .clk             (clk),
    .reset           (reset),
    .stall           (stall),
    .redirect        (redirect),
    .redirect_target (redirect_target),
    .PC              (PC),
    .instruction     (instruction),
    .if_id_pc        (if_id_pc),
    .if_id_instr     (if_id_instr),
    .if_id_valid     (if_id_valid),
    .misaligned      (misaligned),
    .halted          (halted),
    .fetch_count     (fetch_count)
  );

  always #5 clk = ~clk;

  assign instruction = mem[PC[7:2]];

  function automatic logic [31:0] M(input int i);
    return 32'h1000_0000 + i;
  endfunction

  function automatic stim_t R(input logic rst, st, rd, input logic [31:0] tgt);
    return '{rst, st, rd, tgt};
  endfunction

  function automatic obs_t E(input logic [31:0] pc, id_pc, id_instr, cnt,
                             input logic v, h, m);
    return '{pc, id_pc, id_instr, cnt, v, h, m};
  endfunction

  function automatic obs_t sample();
    return '{PC, if_id_pc, if_id_instr, fetch_count, if_id_valid, halted, misaligned};
  endfunction

  function automatic string fmt(input obs_t o);
    return $sformatf("pc=%h id_pc=%h id_instr=%h cnt=%0d valid=%b halted=%b mis=%b",
                     o.pc, o.id_pc, o.id_instr, o.cnt, o.v, o.h, o.m);
  endfunction

  task automatic drive(input stim_t x);
    reset           = x.rst;
    stall           = x.st;
    redirect        = x.rd;
    redirect_target = x.tgt;
  endtask

  task automatic test_reset();
    stim_t s[$];
    obs_t  e[$];
    obs_t  got, want;
    s.push_back(R(1, 1, 1, 32'h46)); e.push_back(E(0, 0, NOP, 0, 0, 0, 0));
    s.push_back(R(1, 0, 0, 32'h0));  e.push_back(E(0, 0, NOP, 0, 0, 0, 0));
    for (int i = 0; i < s.size(); i++) begin
      drive(s[i]);
      sb.push_back(e[i]);
      @(posedge clk); #1;
      got  = sample();
      want = sb.pop_front();
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL reset row %0d: got %s, want %s", i, fmt(got), fmt(want));
      end
    end
  endtask

  task automatic test_free_run();
    stim_t s[$];
    obs_t  e[$];
    obs_t  got, want;
    s.push_back(R(1, 0, 0, 0)); e.push_back(E(0, 0, NOP, 0, 0, 0, 0));
    s.push_back(R(0, 1, 0, 0)); e.push_back(E(0, 0, NOP, 0, 0, 0, 0));
    s.push_back(R(0, 0, 0, 0)); e.push_back(E(4, 0, M(0), 1, 1, 0, 0));
    s.push_back(R(0, 0, 0, 0)); e.push_back(E(8, 4, M(1), 2, 1, 0, 0));
    s.push_back(R(0, 0, 0, 0)); e.push_back(E(12, 8, M(2), 3, 1, 0, 0));
    for (int i = 0; i < s.size(); i++) begin
      drive(s[i]);
      sb.push_back(e[i]);
      @(posedge clk); #1;
      got  = sample();
      want = sb.pop_front();
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL free_run row %0d: got %s, want %s", i, fmt(got), fmt(want));
      end
    end
  endtask

  task automatic test_stall();
    stim_t s[$];
    obs_t  e[$];
    obs_t  got, want;
    s.push_back(R(1, 0, 0, 0)); e.push_back(E(0, 0, NOP, 0, 0, 0, 0));
    s.push_back(R(0, 0, 0, 0)); e.push_back(E(0, 0, NOP, 0, 0, 0, 0));
    s.push_back(R(0, 0, 0, 0)); e.push_back(E(4, 0, M(0), 1, 1, 0, 0));
    s.push_back(R(0, 0, 0, 0)); e.push_back(E(8, 4, M(1), 2, 1, 0, 0));
    for (int k = 0; k < 3; k++) begin
      s.push_back(R(0, 1, 0, 0)); e.push_back(E(8, 4, M(1), 2, 1, 0, 0));
    end
    s.push_back(R(0, 0, 0, 0)); e.push_back(E(12, 8, M(2), 3, 1, 0, 0));
    for (int i = 0; i < s.size(); i++) begin
      drive(s[i]);
      sb.push_back(e[i]);
      @(posedge clk); #1;
      got  = sample();
      want = sb.pop_front();
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL stall row %0d: got %s, want %s", i, fmt(got), fmt(want));
      end
    end
  endtask

  task automatic test_redirect();
    stim_t s[$];
    obs_t  e[$];
    obs_t  got, want;
    s.push_back(R(1, 0, 0, 0));     e.push_back(E(0, 0, NOP, 0, 0, 0, 0));
    s.push_back(R(0, 0, 0, 0));     e.push_back(E(0, 0, NOP, 0, 0, 0, 0));
    s.push_back(R(0, 0, 0, 0));     e.push_back(E(4, 0, M(0), 1, 1, 0, 0));
    s.push_back(R(0, 0, 0, 0));     e.push_back(E(8, 4, M(1), 2, 1, 0, 0));
    s.push_back(R(0, 1, 1, 32'h40)); e.push_back(E(32'h40, 4, NOP, 2, 0, 0, 0));
    s.push_back(R(0, 0, 0, 0));     e.push_back(E(32'h44, 32'h40, M(16), 3, 1, 0, 0));
    for (int i = 0; i < s.size(); i++) begin
      drive(s[i]);
      sb.push_back(e[i]);
      @(posedge clk); #1;
      got  = sample();
      want = sb.pop_front();
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL redirect row %0d: got %s, want %s", i, fmt(got), fmt(want));
      end
    end
  endtask

  task automatic test_misaligned();
    stim_t s[$];
    obs_t  e[$];
    obs_t  got, want;
    s.push_back(R(1, 0, 0, 0));     e.push_back(E(0, 0, NOP, 0, 0, 0, 0));
    s.push_back(R(0, 0, 0, 0));     e.push_back(E(0, 0, NOP, 0, 0, 0, 0));
    s.push_back(R(0, 0, 1, 32'h46)); e.push_back(E(32'h44, 0, NOP, 0, 0, 0, 1));
    s.push_back(R(0, 0, 1, 32'h20)); e.push_back(E(32'h20, 0, NOP, 0, 0, 0, 1));
    s.push_back(R(0, 0, 0, 0));     e.push_back(E(32'h24, 32'h20, M(8), 1, 1, 0, 1));
    s.push_back(R(1, 0, 0, 0));     e.push_back(E(0, 0, NOP, 0, 0, 0, 0));
    for (int i = 0; i < s.size(); i++) begin
      drive(s[i]);
      sb.push_back(e[i]);
      @(posedge clk); #1;
      got  = sample();
      want = sb.pop_front();
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL misaligned row %0d: got %s, want %s", i, fmt(got), fmt(want));
      end
    end
  endtask

  task automatic test_halt();
    stim_t s[$];
    obs_t  e[$];
    obs_t  got, want;
    mem[3] = HALT;
    s.push_back(R(1, 0, 0, 0));     e.push_back(E(0, 0, NOP, 0, 0, 0, 0));
    s.push_back(R(0, 0, 0, 0));     e.push_back(E(0, 0, NOP, 0, 0, 0, 0));
    s.push_back(R(0, 0, 0, 0));     e.push_back(E(4, 0, M(0), 1, 1, 0, 0));
    s.push_back(R(0, 0, 0, 0));     e.push_back(E(8, 4, M(1), 2, 1, 0, 0));
    s.push_back(R(0, 0, 0, 0));     e.push_back(E(12, 8, M(2), 3, 1, 0, 0));
    s.push_back(R(0, 0, 0, 0));     e.push_back(E(12, 12, HALT, 4, 1, 1, 0));
    s.push_back(R(0, 0, 1, 32'h46)); e.push_back(E(12, 12, NOP, 4, 0, 1, 0));
    s.push_back(R(0, 1, 0, 0));     e.push_back(E(12, 12, NOP, 4, 0, 1, 0));
    s.push_back(R(0, 0, 0, 0));     e.push_back(E(12, 12, NOP, 4, 0, 1, 0));
    s.push_back(R(1, 0, 0, 0));     e.push_back(E(0, 0, NOP, 0, 0, 0, 0));
    for (int i = 0; i < s.size(); i++) begin
      drive(s[i]);
      sb.push_back(e[i]);
      @(posedge clk); #1;
      got  = sample();
      want = sb.pop_front();
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL halt row %0d: got %s, want %s", i, fmt(got), fmt(want));
      end
    end
    mem[3] = M(3);
  endtask

  task automatic test_redirect_beats_halt();
    stim_t s[$];
    obs_t  e[$];
    obs_t  got, want;
    mem[3] = HALT;
    s.push_back(R(1, 0, 0, 0));     e.push_back(E(0, 0, NOP, 0, 0, 0, 0));
    s.push_back(R(0, 0, 0, 0));     e.push_back(E(0, 0, NOP, 0, 0, 0, 0));
    s.push_back(R(0, 0, 0, 0));     e.push_back(E(4, 0, M(0), 1, 1, 0, 0));
    s.push_back(R(0, 0, 0, 0));     e.push_back(E(8, 4, M(1), 2, 1, 0, 0));
    s.push_back(R(0, 0, 0, 0));     e.push_back(E(12, 8, M(2), 3, 1, 0, 0));
    s.push_back(R(0, 1, 0, 0));     e.push_back(E(12, 8, M(2), 3, 1, 0, 0));
    s.push_back(R(0, 0, 1, 32'h40)); e.push_back(E(32'h40, 8, NOP, 3, 0, 0, 0));
    s.push_back(R(0, 0, 0, 0));     e.push_back(E(32'h44, 32'h40, M(16), 4, 1, 0, 0));
    for (int i = 0; i < s.size(); i++) begin
      drive(s[i]);
      sb.push_back(e[i]);
      @(posedge clk); #1;
      got  = sample();
      want = sb.pop_front();
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL redirect_vs_halt row %0d: got %s, want %s", i, fmt(got), fmt(want));
      end
    end
    mem[3] = M(3);
  endtask

  task automatic test_wrap();
    stim_t s[$];
    obs_t  e[$];
    obs_t  got, want;
    s.push_back(R(1, 0, 0, 0));            e.push_back(E(0, 0, NOP, 0, 0, 0, 0));
    s.push_back(R(0, 0, 0, 0));            e.push_back(E(0, 0, NOP, 0, 0, 0, 0));
    s.push_back(R(0, 0, 1, 32'hFFFF_FFFC)); e.push_back(E(32'hFFFF_FFFC, 0, NOP, 0, 0, 0, 0));
    s.push_back(R(0, 0, 0, 0));            e.push_back(E(0, 32'hFFFF_FFFC, M(63), 1, 1, 0, 0));
    s.push_back(R(0, 0, 0, 0));            e.push_back(E(4, 0, M(0), 2, 1, 0, 0));
    for (int i = 0; i < s.size(); i++) begin
      drive(s[i]);
      sb.push_back(e[i]);
      @(posedge clk); #1;
      got  = sample();
      want = sb.pop_front();
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL wrap row %0d: got %s, want %s", i, fmt(got), fmt(want));
      end
    end
  endtask

  task automatic test_reset_override();
    stim_t s[$];
    obs_t  e[$];
    obs_t  got, want;
    s.push_back(R(1, 0, 0, 0));     e.push_back(E(0, 0, NOP, 0, 0, 0, 0));
    s.push_back(R(0, 0, 0, 0));     e.push_back(E(0, 0, NOP, 0, 0, 0, 0));
    s.push_back(R(0, 0, 0, 0));     e.push_back(E(4, 0, M(0), 1, 1, 0, 0));
    s.push_back(R(1, 1, 0, 0));     e.push_back(E(0, 0, NOP, 0, 0, 0, 0));
    s.push_back(R(0, 0, 0, 0));     e.push_back(E(0, 0, NOP, 0, 0, 0, 0));
    s.push_back(R(0, 0, 0, 0));     e.push_back(E(4, 0, M(0), 1, 1, 0, 0));
    s.push_back(R(0, 0, 0, 0));     e.push_back(E(8, 4, M(1), 2, 1, 0, 0));
    s.push_back(R(1, 0, 1, 32'h46)); e.push_back(E(0, 0, NOP, 0, 0, 0, 0));
    s.push_back(R(0, 0, 0, 0));     e.push_back(E(0, 0, NOP, 0, 0, 0, 0));
    s.push_back(R(0, 0, 0, 0));     e.push_back(E(4, 0, M(0), 1, 1, 0, 0));
    for (int i = 0; i < s.size(); i++) begin
      drive(s[i]);
      sb.push_back(e[i]);
      @(posedge clk); #1;
      got  = sample();
      want = sb.pop_front();
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL reset_override row %0d: got %s, want %s", i, fmt(got), fmt(want));
      end
    end
    // Reset raised mid-cycle must not disturb outputs until the next edge.
    drive(R(1, 1, 0, 0));
    sb.push_back(E(4, 0, M(0), 1, 1, 0, 0));
    #2;
    got  = sample();
    want = sb.pop_front();
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL reset_between_edges: got %s, want %s", fmt(got), fmt(want));
    end
    sb.push_back(E(0, 0, NOP, 0, 0, 0, 0));
    @(posedge clk); #1;
    got  = sample();
    want = sb.pop_front();
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL reset_at_edge: got %s, want %s", fmt(got), fmt(want));
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = M(i);
    drive(R(1, 0, 0, 0));
    test_reset();
    test_free_run();
    test_stall();
    test_redirect();
    test_misaligned();
    test_halt();
    test_redirect_beats_halt();
    test_wrap();
    test_reset_override();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
